fir_mc_seq: RTL and testbench
=============================

Name: fir_mc_seq

Overview:
- Parametrised successor to the single-channel FIR: time-multiplexed, multi-channel, sequential-MAC FIR filter with run-time programmable coefficients.
- One shared multiplier-accumulator; each channel has its own sample history; all channels share one coefficient set.
- Keeps the per-sample input_valid/output_valid handshake, and adds ready back-pressure, channel tagging, coefficient write and history flush.
- Sits between the sample source and downstream decimation/scaling logic.

Parameters:
- IN_WIDTH, 16, signed input sample width.
- COEF_WIDTH, 16, signed coefficient width.
- TAPS, 64, number of taps, >=2.
- NUM_CH, 2, number of channels, >=1.
- CH_W, max(1,clog2(NUM_CH)), channel-index width.
- OUT_WIDTH, IN_WIDTH+COEF_WIDTH+clog2(TAPS) (38 at defaults), accumulator and output width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- FIR_input  in  IN_WIDTH  signed sample.
- input_ch  in  CH_W  channel of FIR_input.
- input_valid  in  1  sample offered.
- ready  out  1  block can accept a sample this cycle.
- FIR_output  out  OUT_WIDTH  signed filter result.
- output_ch  out  CH_W  channel of FIR_output.
- output_valid  out  1  one-cycle pulse, FIR_output/output_ch valid.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  tap index.
- coef_data  in  COEF_WIDTH  signed coefficient.
- flush  in  1  zero all channel histories.

Behaviour:
- Reset (rst=0, async): state=IDLE; ready=1 after release; FIR_output=0; output_ch=0; output_valid=0; all histories=0; coef[0]=1 and coef[1..TAPS-1]=0, so the filter is identity after reset.
- States: IDLE, MAC, DONE.
- IDLE, ready=1: on an edge with input_valid=1 and input_ch<NUM_CH, the sample is accepted (edge E0).
  - Sample is written into that channel's circular history as x[n]; acc=0; k=0; state->MAC.
  - input_ch>=NUM_CH: sample ignored, no output, stays IDLE.
- MAC, ready=0: each edge does acc += coef[k]*x[n-k], k++. Edges E1..E(TAPS). The edge with k=TAPS-1 moves state->DONE.
- DONE, ready=0: edge E(TAPS+1) registers FIR_output=acc and output_ch=channel, sets output_valid=1, state->IDLE.
- output_valid is high for exactly the cycle after E(TAPS+1); ready is high in that same cycle.
- Latency: accept to output_valid = TAPS+1 edges. Maximum throughput is one sample per TAPS+2 cycles.
- FIR_output holds its value until the next result.
- Arithmetic:
  - Signed two's complement throughout; products at full IN_WIDTH+COEF_WIDTH precision, sign-extended to OUT_WIDTH.
  - No rounding, truncation or saturation; OUT_WIDTH at its default cannot overflow.
  - A user-overridden smaller OUT_WIDTH wraps modulo 2^OUT_WIDTH.
- History:
  - Per-channel write pointer wraps TAPS-1 -> 0.
  - Samples older than TAPS-1 are overwritten.
  - Channels never share or disturb each other's history.
- Coefficient writes: accepted only in IDLE with no accept on the same edge, writing coef[coef_addr]=coef_data. Writes in MAC/DONE, or on the edge a sample is accepted, are ignored, so coefficients never change mid-convolution.
- flush: in IDLE, zeroes every history and pointer in one edge, has priority over a simultaneous input_valid (sample dropped), and leaves coefficients intact. Ignored outside IDLE.
- input_valid while ready=0: ignored (not queued); the source must hold it until ready=1.
- Reset mid-operation: the in-flight result is discarded, no output_valid is produced, and all state returns to reset values, coefficients included.

Test Plan:
- Reset, then ch0 inputs 5, -3, 32767 -> outputs 5, -3, 32767 sign-extended; output_valid at exactly E0+TAPS+1; output_ch=0.
- Load coef[0..3]=1,2,3,4 (rest 0), ch0 impulse 1 followed by zeros -> outputs 1,2,3,4,0,0.
- Interleave ch0=100 and ch1=-100 impulses with coef[0..3]=1,2,3,4 -> ch0 outputs 100,200,300,400; ch1 outputs -100,-200,-300,-400; no cross-channel leakage.
- All coefs=-32768, TAPS consecutive ch0 inputs -32768 -> final output = 64*2^30 = 2^36, no overflow at OUT_WIDTH=38.
- coef_we during MAC, input_valid while ready=0, and input_ch=NUM_CH -> all ignored: coefficients unchanged, outputs match the model, no extra output_valid.
- Flush after history is loaded, then impulse -> impulse response only; rst low during MAC -> no output_valid, identity coefficients restored.

Source files
------------

// File: rtl/fir_mc_seq_if.sv
// Sample/result/coefficient bus between a sample source and the multi-channel FIR.
// Latency: none, wires only.
// Backpressure: ready low means the source must hold input_valid until it rises.
interface fir_mc_seq_if #(
  parameter int IN_WIDTH   = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 64,
  parameter int NUM_CH     = 2,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int OUT_WIDTH  = IN_WIDTH + COEF_WIDTH + $clog2(TAPS)
);
  localparam int AW = $clog2(TAPS);

  logic signed [IN_WIDTH-1:0]   FIR_input;
  logic        [CH_W-1:0]       input_ch;
  logic                         input_valid;
  logic                         ready;
  logic signed [OUT_WIDTH-1:0]  FIR_output;
  logic        [CH_W-1:0]       output_ch;
  logic                         output_valid;
  logic                         coef_we;
  logic        [AW-1:0]         coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_data;
  logic                         flush;

  modport master (
    output FIR_input, input_ch, input_valid, coef_we, coef_addr, coef_data, flush,
    input  ready, FIR_output, output_ch, output_valid
  );

  modport slave (
    input  FIR_input, input_ch, input_valid, coef_we, coef_addr, coef_data, flush,
    output ready, FIR_output, output_ch, output_valid
  );
endinterface

// File: rtl/fir_mc_seq.sv
// Time-multiplexed multi-channel FIR: one shared MAC, per-channel history, shared coefficients.
// Latency: accept to output_valid is TAPS+1 edges; one sample per TAPS+2 cycles at best.
// Backpressure: ready is high only in IDLE; input_valid while ready is low is ignored, not queued.
module fir_mc_seq #(
  parameter int IN_WIDTH   = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 64,
  parameter int NUM_CH     = 2,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int OUT_WIDTH  = IN_WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
  input logic         clk,
  input logic         rst,
  fir_mc_seq_if.slave bus
);
  localparam int              AW     = $clog2(TAPS);
  localparam int              PW     = IN_WIDTH + COEF_WIDTH;
  localparam logic [AW-1:0]   K_LAST = AW'(TAPS - 1);
  localparam logic [CH_W:0]   NCH    = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state, state_nxt;

  logic signed [IN_WIDTH-1:0]   hist [NUM_CH][TAPS];
  logic        [AW-1:0]         wptr [NUM_CH];
  logic signed [COEF_WIDTH-1:0] coef [TAPS];

  logic        [CH_W-1:0]       cur_ch;
  logic        [AW-1:0]         rd_ptr;
  logic        [AW-1:0]         k;
  logic signed [OUT_WIDTH-1:0]  acc;

  logic                         accept;
  logic                         flush_en;
  logic                         coef_wr;
  logic signed [PW-1:0]         prod;
  logic signed [OUT_WIDTH-1:0]  prod_ext;

  // Flush wins over a simultaneous sample; out-of-range channels are dropped silently.
  assign flush_en = (state == IDLE) && bus.flush;
  assign accept   = (state == IDLE) && bus.input_valid && !bus.flush &&
                    ({1'b0, bus.input_ch} < NCH);
  // Coefficients may only change between convolutions.
  assign coef_wr  = (state == IDLE) && bus.coef_we && !accept;

  // Full-precision product, sign-extended (or wrapped) to the accumulator width.
  assign prod     = hist[cur_ch][rd_ptr] * coef[k];
  assign prod_ext = OUT_WIDTH'(prod);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: accept starts a convolution, last tap goes to DONE, DONE publishes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (k == K_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: the block takes samples only while idle.
  always_comb begin
    bus.ready = (state == IDLE);
  end

  // MAC datapath and result register; rd_ptr walks backwards from x[n] to x[n-TAPS+1].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc              <= '0;
      k                <= '0;
      rd_ptr           <= '0;
      cur_ch           <= '0;
      bus.FIR_output   <= '0;
      bus.output_ch    <= '0;
      bus.output_valid <= 1'b0;
    end else begin
      bus.output_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          acc    <= '0;
          k      <= '0;
          rd_ptr <= wptr[bus.input_ch];
          cur_ch <= bus.input_ch;
        end
        MAC: begin
          acc    <= acc + prod_ext;
          k      <= k + 1'b1;
          rd_ptr <= (rd_ptr == '0) ? K_LAST : rd_ptr - 1'b1;
        end
        DONE: begin
          bus.FIR_output   <= acc;
          bus.output_ch    <= cur_ch;
          bus.output_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-channel circular histories; flush clears every channel and pointer at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr[c] <= '0;
        for (int t = 0; t < TAPS; t++) hist[c][t] <= '0;
      end
    end else if (flush_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr[c] <= '0;
        for (int t = 0; t < TAPS; t++) hist[c][t] <= '0;
      end
    end else if (accept) begin
      hist[bus.input_ch][wptr[bus.input_ch]] <= bus.FIR_input;
      wptr[bus.input_ch] <= (wptr[bus.input_ch] == K_LAST) ? '0 : wptr[bus.input_ch] + 1'b1;
    end
  end

  // Coefficient bank; reset value makes the filter an identity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < TAPS; t++) coef[t] <= '0;
      coef[0] <= COEF_WIDTH'(1);
    end else if (coef_wr) begin
      coef[bus.coef_addr] <= bus.coef_data;
    end
  end
endmodule

// File: tb/tb_fir_mc_seq.sv
// Directed bench for fir_mc_seq with hand-computed expected outputs.
// Latency: checks accept-to-output_valid of TAPS+1 edges.
// Backpressure: drives stimulus while busy and confirms it is ignored.
module tb_fir_mc_seq;
  localparam int TAPS   = 64;
  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;
  localparam int OW     = 38;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fir_mc_seq_if #(.NUM_CH(NUM_CH)) bus();
  fir_mc_seq #(.NUM_CH(NUM_CH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  int out_cnt = 0;
  int exp_outs = 0;

  // Every output_valid pulse is counted so stray results show up at the end.
  always @(negedge clk) if (bus.output_valid === 1'b1) out_cnt++;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_ready();
    int w = 0;
    @(negedge clk);
    while (!bus.ready && w < 200) begin @(negedge clk); w++; end
    if (!bus.ready) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_out(output logic signed [OW-1:0] y, output logic [CH_W-1:0] yc,
                          output int lat);
    lat = 0; y = '0; yc = '0;
    while (lat < TAPS + 10) begin
      @(negedge clk); lat++;
      if (bus.output_valid) break;
    end
    if (bus.output_valid) begin y = bus.FIR_output; yc = bus.output_ch; end
  endtask

  task automatic run(input string tag, input int ch, input int x, input longint expv);
    logic signed [OW-1:0] y;
    logic [CH_W-1:0] yc;
    int lat;
    wait_ready();
    bus.FIR_input = 16'(x); bus.input_ch = CH_W'(ch); bus.input_valid = 1'b1;
    @(negedge clk);
    bus.input_valid = 1'b0;
    exp_outs++;
    wait_out(y, yc, lat);
    check({tag, "_y"}, y, expv);
    check({tag, "_ch"}, yc, ch);
    check({tag, "_lat"}, lat, TAPS + 1);
  endtask

  task automatic wcoef(input int a, input int d);
    @(negedge clk);
    bus.coef_we = 1'b1; bus.coef_addr = 6'(a); bus.coef_data = 16'(d);
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  task automatic load_1234();
    for (int i = 0; i < TAPS; i++) wcoef(i, (i < 4) ? i + 1 : 0);
  endtask

  initial begin
    logic signed [OW-1:0] y;
    logic [CH_W-1:0] yc;
    int lat;
    int base;

    bus.FIR_input = '0; bus.input_ch = '0; bus.input_valid = 1'b0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", bus.ready, 1);
    check("rst_out", bus.FIR_output, 0);
    check("rst_och", bus.output_ch, 0);
    check("rst_ovld", bus.output_valid, 0);

    // Identity after reset.
    run("id5", 0, 5, 5);
    run("idm3", 0, -3, -3);
    run("idmax", 0, 32767, 32767);

    // Impulse response of 1,2,3,4.
    load_1234();
    do_flush();
    for (int i = 0; i < 6; i++) run("imp", 0, (i == 0) ? 1 : 0, (i < 4) ? i + 1 : 0);

    // Interleaved channels must not leak into each other.
    do_flush();
    for (int i = 0; i < 4; i++) begin
      run("ilv0", 0, (i == 0) ? 100 : 0, 100 * (i + 1));
      run("ilv1", 1, (i == 0) ? -100 : 0, -100 * (i + 1));
    end

    // Worst-case magnitude: k-th output is k * 2^30, last is 2^36.
    for (int i = 0; i < TAPS; i++) wcoef(i, -32768);
    do_flush();
    for (int i = 0; i < TAPS; i++) run("big", 0, -32768, longint'(i + 1) * (64'sd1 <<< 30));

    // Writes and samples while busy, plus an out-of-range channel, are ignored.
    load_1234();
    do_flush();
    wait_ready();
    bus.FIR_input = 16'(10); bus.input_ch = 2'd0; bus.input_valid = 1'b1;
    @(negedge clk);
    bus.input_valid = 1'b0;
    exp_outs++;
    repeat (4) @(negedge clk);
    check("busy_rdy", bus.ready, 0);
    bus.coef_we = 1'b1; bus.coef_addr = 6'd0; bus.coef_data = 16'(99);
    bus.FIR_input = 16'(555); bus.input_ch = 2'd1; bus.input_valid = 1'b1;
    @(negedge clk);
    bus.coef_we = 1'b0; bus.input_valid = 1'b0;
    wait_out(y, yc, lat);
    check("busy_y", y, 10);
    check("busy_ch", yc, 0);
    wait_ready();
    bus.FIR_input = 16'(1234); bus.input_ch = 2'd3; bus.input_valid = 1'b1;
    @(negedge clk);
    bus.input_valid = 1'b0;
    check("badch_rdy", bus.ready, 1);
    repeat (TAPS + 5) @(negedge clk);
    run("ch1_clean", 1, 7, 7);
    run("coef_kept", 0, 1, 21);
    run("ch2_clean", 2, 5, 5);

    // Flush beats a simultaneous sample and keeps coefficients.
    wait_ready();
    bus.flush = 1'b1; bus.FIR_input = 16'(50); bus.input_ch = 2'd0; bus.input_valid = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.input_valid = 1'b0;
    check("flush_rdy", bus.ready, 1);
    run("flush_imp0", 0, 1, 1);
    run("flush_imp1", 0, 0, 2);

    // Reset mid-convolution: result dropped, coefficients back to identity.
    wcoef(0, 3);
    wait_ready();
    bus.FIR_input = 16'(9); bus.input_ch = 2'd0; bus.input_valid = 1'b1;
    @(negedge clk);
    bus.input_valid = 1'b0;
    base = out_cnt;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (TAPS + 10) @(negedge clk);
    #1;
    check("rstmid_noout", out_cnt - base, 0);
    check("rstmid_rdy", bus.ready, 1);
    check("rstmid_out", bus.FIR_output, 0);
    run("rstmid_id0", 0, 7, 7);
    run("rstmid_id1", 0, 5, 5);

    repeat (3) @(negedge clk);
    #1;
    check("out_count", out_cnt, exp_outs);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
